instr_encoder: RTL and testbench
================================

// Module: instr_encoder
// PURPOSE
//  Inverse of the main/ALU decode path: packs RISC-V RV32I instruction fields (format, opcode, funct3/7,
//  rd, rs1, rs2, imm) into 32-bit instruction words. Emits them through a 1-entry output register, with a
//  sequential word address, toward instruction memory (program loader / self-test stimulus for decoder).
//  Input and output each use a valid/ready handshake. A word counter tracks the memory fill level.
// PARAMETERS
//  ADDR_W     6   instruction-memory word-address width; DEPTH = 2**ADDR_W words
//  BASE_ADDR  0   word address assigned to the first emitted instruction (ADDR_W bits)
// PORTS
//  clk        in   1       rising-edge clock
//  reset      in   1       asynchronous, active-high reset
//  clear      in   1       synchronous: restart at BASE_ADDR, drop pending word, clear fmt_err
//  in_valid   in   1       field set valid
//  in_ready   out  1       encoder can accept a field set this cycle
//  fmt        in   3       0=R 1=I 2=S 3=B 4=U 5=J; 6,7 illegal
//  opcode     in   7       instr[6:0]
//  funct3     in   3       instr[14:12] (R/I/S/B)
//  funct7     in   7       instr[31:25] (R only)
//  rd         in   5       destination register (R/I/U/J)
//  rs1        in   5       source 1 (R/I/S/B)
//  rs2        in   5       source 2 (R/S/B)
//  imm        in   32      immediate, byte offset for B/J; unused bits ignored
//  out_valid  out  1       instr/addr hold a word for memory
//  out_ready  in   1       memory takes the word this cycle
//  instr      out  32      encoded instruction
//  addr       out  ADDR_W  word address for instr
//  count      out  ADDR_W+1 words written since reset/clear (out handshakes)
//  mem_full   out  1       count + out_valid == DEPTH
//  fmt_err    out  1       sticky: an illegal fmt was received
// BEHAVIOUR
//  Reset (async): out_valid=0, instr=0, addr=BASE_ADDR, count=0, fmt_err=0. in_ready=1 immediately after.
//  Encoding (combinational on inputs, registered on accept):
//   R: {funct7,rs2,rs1,funct3,rd,opcode}    I: {imm[11:0],rs1,funct3,rd,opcode}
//   S: {imm[11:5],rs2,rs1,funct3,imm[4:0],opcode}
//   B: {imm[12],imm[10:5],rs2,rs1,funct3,imm[4:1],imm[11],opcode}
//   U: {imm[31:12],rd,opcode}    J: {imm[20],imm[10:1],imm[11],imm[19:12],rd,opcode}
//  in_ready = !mem_full && (!out_valid || out_ready). Accept = in_valid && in_ready.
//  Accept with legal fmt: instr loaded, out_valid=1 next edge (latency 1 clock). Accept with fmt 6/7:
//   handshake completes, no word produced, fmt_err set and held until reset/clear.
//  Out handshake (out_valid && out_ready): count+1, addr+1 mod DEPTH, same edge. If no accept on the same
//   edge, out_valid=0. Accept on the same edge: new word loaded, out_valid stays 1 (full throughput, 1/clk).
//  out_valid=1 && !out_ready: instr/addr stable, in_ready=0.
//  mem_full once DEPTH words are written or pending. in_ready stays 0 until clear/reset. addr wraps to
//   BASE_ADDR modulo DEPTH but does not advance past the last word while full.
//  clear has priority over accept and handshake: same state as reset except synchronous. No word is
//   written to memory in that cycle.
//  Reset mid-transfer: pending word discarded, memory not written (out_valid low asynchronously).
// TESTING
//  R add x3,x1,x2 (op 0x33,f3 0,f7 0) -> instr 0x002081B3, addr 0, out_valid one clk after accept
//  I addi x5,x0,-1 (op 0x13, imm 0xFFFFFFFF) -> 0xFFF00293; S sw x2,8(x1) (op 0x23,f3 2) -> 0x0020A423
//  B beq x1,x2,-4 (op 0x63, imm 0xFFFFFFFC) -> 0xFE208EE3; J jal x1,8 (op 0x6F) -> 0x008000EF
//  ADDR_W=2, out_ready=1, 5 back-to-back inputs -> 4 words at addr 0..3, 1/clk; then mem_full=1, in_ready=0
//  out_ready=0 for 3 clks with in_valid=1 -> instr/addr held, in_ready=0, no input lost or duplicated
//  fmt=7 -> accepted, no out_valid, fmt_err=1; clear -> fmt_err=0, count=0; async reset mid-stall -> defaults

Source files
------------

// File: rtl/instr_encoder_if.sv
// Handshake bundle between a field-set producer, the instruction encoder
// and instruction memory.
interface instr_encoder_if #(
    parameter int ADDR_W = 6
);
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        fmt;
    logic [6:0]        opcode;
    logic [2:0]        funct3;
    logic [6:0]        funct7;
    logic [4:0]        rd;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [31:0]       imm;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       instr;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W:0]   count;
    logic              mem_full;
    logic              fmt_err;

    modport master (
        output in_valid, fmt, opcode, funct3, funct7,
        output rd, rs1, rs2, imm, out_ready,
        input  in_ready, out_valid, instr, addr,
        input  count, mem_full, fmt_err
    );

    modport slave (
        input  in_valid, fmt, opcode, funct3, funct7,
        input  rd, rs1, rs2, imm, out_ready,
        output in_ready, out_valid, instr, addr,
        output count, mem_full, fmt_err
    );
endinterface

// File: rtl/instr_encoder.sv
// RV32I field packer: encodes field sets into instruction words and
// streams them with sequential word addresses into instruction memory.
module instr_encoder #(
    parameter int                ADDR_W    = 6,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            clear,
    instr_encoder_if.slave  io_bus
);
    localparam logic [ADDR_W:0] DEPTH_C = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] ADR_ONE = ADDR_W'(1);

    logic              r_valid;
    logic [31:0]       r_instr;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W:0]   r_count;
    logic              r_err;

    logic              w_full;
    logic              w_ready;
    logic              w_accept;
    logic              w_hs;
    logic              w_legal;
    logic [31:0]       w_word;
    logic [31:0]       w_imm;
    logic [ADDR_W:0]   w_used;

    assign w_imm    = io_bus.imm;
    // A pending word already owns a memory slot.
    assign w_used   = r_count + {{ADDR_W{1'b0}}, r_valid};
    assign w_full   = (w_used == DEPTH_C);
    assign w_ready  = !w_full && (!r_valid || io_bus.out_ready);
    assign w_accept = io_bus.in_valid && w_ready;
    assign w_hs     = r_valid && io_bus.out_ready;

    always_comb begin
        w_word  = '0;
        w_legal = 1'b1;
        case (io_bus.fmt)
            3'd0: w_word = {io_bus.funct7, io_bus.rs2, io_bus.rs1,
                            io_bus.funct3, io_bus.rd, io_bus.opcode};
            3'd1: w_word = {w_imm[11:0], io_bus.rs1, io_bus.funct3,
                            io_bus.rd, io_bus.opcode};
            3'd2: w_word = {w_imm[11:5], io_bus.rs2, io_bus.rs1,
                            io_bus.funct3, w_imm[4:0], io_bus.opcode};
            3'd3: w_word = {w_imm[12], w_imm[10:5], io_bus.rs2,
                            io_bus.rs1, io_bus.funct3, w_imm[4:1],
                            w_imm[11], io_bus.opcode};
            3'd4: w_word = {w_imm[31:12], io_bus.rd, io_bus.opcode};
            3'd5: w_word = {w_imm[20], w_imm[10:1], w_imm[11],
                            w_imm[19:12], io_bus.rd, io_bus.opcode};
            default: w_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_instr <= '0;
            r_addr  <= BASE_ADDR;
            r_count <= '0;
            r_err   <= 1'b0;
        end else if (clear) begin
            r_valid <= 1'b0;
            r_instr <= '0;
            r_addr  <= BASE_ADDR;
            r_count <= '0;
            r_err   <= 1'b0;
        end else begin
            if (w_hs) begin
                r_count <= r_count + CNT_ONE;
                r_addr  <= r_addr + ADR_ONE;
            end
            // A same-edge accept refills the register for full throughput.
            if (w_accept && w_legal) begin
                r_valid <= 1'b1;
                r_instr <= w_word;
            end else if (w_hs) begin
                r_valid <= 1'b0;
            end
            if (w_accept && !w_legal) begin
                r_err <= 1'b1;
            end
        end
    end

    assign io_bus.in_ready  = w_ready;
    assign io_bus.out_valid = r_valid;
    assign io_bus.instr     = r_instr;
    assign io_bus.addr      = r_addr;
    assign io_bus.count     = r_count;
    assign io_bus.mem_full  = w_full;
    assign io_bus.fmt_err   = r_err;
endmodule

// File: tb/tb_instr_encoder.sv
// Directed self-checking bench for instr_encoder with a 4-word memory.
module tb_instr_encoder;
    logic clk;
    logic reset;
    logic clear;
    int   checks;
    int   errors;

    instr_encoder_if #(.ADDR_W(2)) bus ();

    instr_encoder #(
        .ADDR_W    (2),
        .BASE_ADDR (2'd0)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .clear  (clear),
        .io_bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [2:0]  fmt;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [6];

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        cyc();
        clear = 1'b0;
    endtask

    task automatic set_r(input logic [4:0] rd_v);
        bus.fmt    = 3'd0;
        bus.opcode = 7'h33;
        bus.funct3 = 3'd0;
        bus.funct7 = 7'd0;
        bus.rd     = rd_v;
        bus.rs1    = 5'd0;
        bus.rs2    = 5'd0;
        bus.imm    = 32'd0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #3;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.instr !== 32'd0) begin
            errors++;
            $display("FAIL reset_out: valid=%b instr=%h want 0/0",
                     bus.out_valid, bus.instr);
        end
        checks++;
        if (bus.addr !== 2'd0 || bus.count !== 3'd0 || bus.fmt_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: addr=%0d count=%0d err=%b want 0/0/0",
                     bus.addr, bus.count, bus.fmt_err);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.mem_full !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready: in_ready=%b full=%b want 1/0",
                     bus.in_ready, bus.mem_full);
        end
        @(negedge clk);
    endtask

    task automatic test_encode();
        vecs[0] = '{"R_add", 3'd0, 7'h33, 3'd0, 7'h00, 5'd3, 5'd1, 5'd2,
                    32'h0, 32'h002081B3};
        vecs[1] = '{"I_addi", 3'd1, 7'h13, 3'd0, 7'h00, 5'd5, 5'd0, 5'd0,
                    32'hFFFFFFFF, 32'hFFF00293};
        vecs[2] = '{"S_sw", 3'd2, 7'h23, 3'd2, 7'h00, 5'd0, 5'd1, 5'd2,
                    32'h8, 32'h0020A423};
        vecs[3] = '{"B_beq", 3'd3, 7'h63, 3'd0, 7'h00, 5'd0, 5'd1, 5'd2,
                    32'hFFFFFFFC, 32'hFE208EE3};
        vecs[4] = '{"J_jal", 3'd5, 7'h6F, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0,
                    32'h8, 32'h008000EF};
        vecs[5] = '{"U_lui", 3'd4, 7'h37, 3'd0, 7'h00, 5'd5, 5'd0, 5'd0,
                    32'h12345000, 32'h123452B7};
        for (int i = 0; i < 6; i++) begin
            do_clear();
            bus.out_ready = 1'b0;
            bus.fmt    = vecs[i].fmt;
            bus.opcode = vecs[i].op;
            bus.funct3 = vecs[i].f3;
            bus.funct7 = vecs[i].f7;
            bus.rd     = vecs[i].rd;
            bus.rs1    = vecs[i].rs1;
            bus.rs2    = vecs[i].rs2;
            bus.imm    = vecs[i].imm;
            bus.in_valid = 1'b1;
            #1;
            checks++;
            if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
                errors++;
                $display("FAIL %s_pre: valid=%b ready=%b want 0/1",
                         vecs[i].name, bus.out_valid, bus.in_ready);
            end
            cyc();
            bus.in_valid = 1'b0;
            checks++;
            if (bus.out_valid !== 1'b1 || bus.instr !== vecs[i].exp ||
                bus.addr !== 2'd0) begin
                errors++;
                $display("FAIL %s: valid=%b instr=%h addr=%0d want 1/%h/0",
                         vecs[i].name, bus.out_valid, bus.instr, bus.addr,
                         vecs[i].exp);
            end
            bus.out_ready = 1'b1;
            cyc();
            bus.out_ready = 1'b0;
            checks++;
            if (bus.out_valid !== 1'b0 || bus.count !== 3'd1 ||
                bus.addr !== 2'd1) begin
                errors++;
                $display("FAIL %s_drain: valid=%b count=%0d addr=%0d want 0/1/1",
                         vecs[i].name, bus.out_valid, bus.count, bus.addr);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp;
        do_clear();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            set_r(5'(i + 1));
            bus.in_valid = (i < 5);
            #1;
            checks++;
            if (bus.in_ready !== (i < 4)) begin
                errors++;
                $display("FAIL b2b_ready%0d: in_ready=%b want %b",
                         i, bus.in_ready, (i < 4));
            end
            if (i >= 1 && i <= 4) begin
                exp = 32'h33 | (32'(i) << 7);
                checks++;
                if (bus.out_valid !== 1'b1 || bus.instr !== exp ||
                    bus.addr !== 2'(i - 1)) begin
                    errors++;
                    $display("FAIL b2b_word%0d: valid=%b instr=%h addr=%0d want 1/%h/%0d",
                             i, bus.out_valid, bus.instr, bus.addr, exp, i - 1);
                end
            end
            cyc();
        end
        bus.in_valid = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.count !== 3'd4 ||
            bus.mem_full !== 1'b1 || bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL b2b_full: valid=%b count=%0d full=%b ready=%b want 0/4/1/0",
                     bus.out_valid, bus.count, bus.mem_full, bus.in_ready);
        end
        bus.out_ready = 1'b0;
    endtask

    task automatic test_stall();
        do_clear();
        bus.out_ready = 1'b0;
        set_r(5'd7);
        bus.in_valid = 1'b1;
        cyc();
        set_r(5'd9);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (bus.out_valid !== 1'b1 || bus.instr !== 32'h000003B3 ||
                bus.addr !== 2'd0 || bus.in_ready !== 1'b0) begin
                errors++;
                $display("FAIL stall%0d: valid=%b instr=%h addr=%0d ready=%b want 1/000003b3/0/0",
                         i, bus.out_valid, bus.instr, bus.addr, bus.in_ready);
            end
            cyc();
        end
        bus.out_ready = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL stall_release: in_ready=%b want 1", bus.in_ready);
        end
        cyc();
        bus.in_valid = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b1 || bus.instr !== 32'h000004B3 ||
            bus.addr !== 2'd1 || bus.count !== 3'd1) begin
            errors++;
            $display("FAIL stall_next: valid=%b instr=%h addr=%0d count=%0d want 1/000004b3/1/1",
                     bus.out_valid, bus.instr, bus.addr, bus.count);
        end
        cyc();
        checks++;
        if (bus.out_valid !== 1'b0 || bus.count !== 3'd2) begin
            errors++;
            $display("FAIL stall_nodup: valid=%b count=%0d want 0/2",
                     bus.out_valid, bus.count);
        end
        bus.out_ready = 1'b0;
    endtask

    task automatic test_fmt_err();
        do_clear();
        bus.out_ready = 1'b1;
        set_r(5'd1);
        bus.in_valid = 1'b1;
        cyc();
        bus.in_valid = 1'b0;
        cyc();
        bus.fmt = 3'd7;
        bus.in_valid = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL fmt7_ready: in_ready=%b want 1", bus.in_ready);
        end
        cyc();
        bus.in_valid = 1'b0;
        cyc();
        checks++;
        if (bus.out_valid !== 1'b0 || bus.fmt_err !== 1'b1 ||
            bus.count !== 3'd1) begin
            errors++;
            $display("FAIL fmt7_err: valid=%b err=%b count=%0d want 0/1/1",
                     bus.out_valid, bus.fmt_err, bus.count);
        end
        // clear must win over a simultaneous handshake and accept
        set_r(5'd2);
        bus.in_valid = 1'b1;
        cyc();
        clear = 1'b1;
        cyc();
        clear = 1'b0;
        bus.in_valid = 1'b0;
        checks++;
        if (bus.fmt_err !== 1'b0 || bus.count !== 3'd0 ||
            bus.out_valid !== 1'b0 || bus.addr !== 2'd0) begin
            errors++;
            $display("FAIL clear: err=%b count=%0d valid=%b addr=%0d want 0/0/0/0",
                     bus.fmt_err, bus.count, bus.out_valid, bus.addr);
        end
        bus.out_ready = 1'b0;
    endtask

    task automatic test_async_reset();
        do_clear();
        bus.out_ready = 1'b1;
        set_r(5'd3);
        bus.in_valid = 1'b1;
        cyc();
        bus.out_ready = 1'b0;
        set_r(5'd4);
        cyc();
        cyc();
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.instr !== 32'd0 ||
            bus.addr !== 2'd0 || bus.count !== 3'd0) begin
            errors++;
            $display("FAIL async_reset: valid=%b instr=%h addr=%0d count=%0d want 0/0/0/0",
                     bus.out_valid, bus.instr, bus.addr, bus.count);
        end
        bus.in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        cyc();
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL post_reset: valid=%b ready=%b want 0/1",
                     bus.out_valid, bus.in_ready);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        clear = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        set_r(5'd0);
        test_reset();
        test_encode();
        test_back_to_back();
        test_stall();
        test_fmt_err();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
